// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state, width and PC-increment encodings for pipeline control
package cpu_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_BR_FLUSH   = 2'd2,
        ST_HALT       = 2'd3
    } ctrl_state_t;

    // haz_mux_con encodings: the PC adder sees increment 2 or increment 0
    localparam logic INC_TWO_SEL  = 1'b0;
    localparam logic INC_ZERO_SEL = 1'b1;

    localparam logic PC_SEL_NEXT   = 1'b0;
    localparam logic PC_SEL_BRANCH = 1'b1;

    localparam logic [15:0] STALL_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between ID sources and EX load
module load_use_detect #(
    parameter int REG_ADDR_W = cpu_ctrl_pkg::REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (ex_rd == id_rs1);
    assign rs2_match = id_uses_rs2 && (ex_rd == id_rs2);

    // r0 is hardwired zero, so a load targeting it never produces a value to wait for
    assign hazard = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - stall/flush/halt control FSM with saturating hold-cycle counter
module pipeline_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int REG_ADDR_W        = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  id_halt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  branch_taken,
    output logic                  pc_mux_sel,
    output logic                  haz_mux_con,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  halted,
    output logic [15:0]           stall_count
);

    ctrl_state_t state;
    logic [2:0]  stall_left;
    logic        hazard;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (hazard)
    );

    // Branch redirect must reach the PC mux in the resolving cycle, so outputs decode state+inputs
    always_comb begin
        pc_mux_sel  = PC_SEL_NEXT;
        haz_mux_con = INC_TWO_SEL;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;
        case (state)
            ST_RUN: begin
                if (branch_taken) begin
                    pc_mux_sel  = PC_SEL_BRANCH;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (hazard || id_halt) begin
                    haz_mux_con = INC_ZERO_SEL;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            ST_LOAD_STALL: begin
                if (branch_taken) begin
                    pc_mux_sel  = PC_SEL_BRANCH;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else begin
                    haz_mux_con = INC_ZERO_SEL;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            ST_BR_FLUSH: begin
                ifid_flush = 1'b1;
                if (branch_taken) begin
                    pc_mux_sel  = PC_SEL_BRANCH;
                    idex_bubble = 1'b1;
                end
            end
            ST_HALT: begin
                haz_mux_con = INC_ZERO_SEL;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                halted      = 1'b1;
            end
            default: begin
                haz_mux_con = INC_ZERO_SEL;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        endcase
        // Reset overrides asynchronously: freeze fetch and feed NOPs until released
        if (!reset) begin
            pc_mux_sel  = PC_SEL_NEXT;
            haz_mux_con = INC_ZERO_SEL;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            stall_left  <= 3'd0;
            stall_count <= 16'd0;
        end else begin
            if ((haz_mux_con == INC_ZERO_SEL) && (state != ST_HALT) &&
                (stall_count != STALL_COUNT_MAX)) begin
                stall_count <= stall_count + 16'd1;
            end
            case (state)
                ST_RUN: begin
                    if (branch_taken) begin
                        state <= ST_BR_FLUSH;
                    end else if (hazard) begin
                        if (LOAD_STALL_CYCLES > 1) begin
                            state      <= ST_LOAD_STALL;
                            stall_left <= 3'(LOAD_STALL_CYCLES - 1);
                        end
                    end else if (id_halt) begin
                        state <= ST_HALT;
                    end
                end
                ST_LOAD_STALL: begin
                    if (branch_taken) begin
                        state      <= ST_BR_FLUSH;
                        stall_left <= 3'd0;
                    end else if (stall_left <= 3'd1) begin
                        state      <= ST_RUN;
                        stall_left <= 3'd0;
                    end else begin
                        stall_left <= stall_left - 3'd1;
                    end
                end
                ST_BR_FLUSH: begin
                    if (!branch_taken) begin
                        state <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - directed scoreboard bench for pipeline_controller
module tb_pipeline_controller;

    localparam logic [5:0] RUN_O   = 6'b001000;
    localparam logic [5:0] STALL_O = 6'b010010;
    localparam logic [5:0] BR_O    = 6'b101110;
    localparam logic [5:0] FLUSH_O = 6'b001100;
    localparam logic [5:0] HALT_O  = 6'b010011;
    localparam logic [5:0] RST_O   = 6'b010110;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_halt = 1'b0;
    logic        ex_mem_read = 1'b0, branch_taken = 1'b0;
    logic        pc_mux_sel, haz_mux_con, ifid_write, ifid_flush, idex_bubble, halted;
    logic [15:0] stall_count;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_sc = 16'd0;
    logic [5:0]  sb[$];

    always #5 clk = ~clk;

    pipeline_controller #(
        .LOAD_STALL_CYCLES (2),
        .REG_ADDR_W        (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_halt      (id_halt),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .branch_taken (branch_taken),
        .pc_mux_sel   (pc_mux_sel),
        .haz_mux_con  (haz_mux_con),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .halted       (halted),
        .stall_count  (stall_count)
    );

    function automatic logic [5:0] obs_vec();
        return {pc_mux_sel, haz_mux_con, ifid_write, ifid_flush, idex_bubble, halted};
    endfunction

    task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s outputs obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s stall_count obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rs1, input logic [3:0] rs2, input logic u1,
                         input logic u2, input logic hlt, input logic [3:0] rd,
                         input logic mr, input logic br);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_halt = hlt; ex_rd = rd; ex_mem_read = mr; branch_taken = br;
    endtask

    // One cycle: drive at negedge, push expectation, pop and compare mid-cycle
    task automatic cyc(input string tag, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic u1, input logic u2, input logic hlt, input logic [3:0] rd,
                       input logic mr, input logic br, input logic [5:0] exp);
        logic [5:0] want;
        @(negedge clk);
        drive(rs1, rs2, u1, u2, hlt, rd, mr, br);
        sb.push_back(exp);
        #1;
        want = sb.pop_front();
        chk6(tag, obs_vec(), want);
        chk16(tag, stall_count, exp_sc);
        if (want[4] && !want[0] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        chk6({tag, "_async"}, obs_vec(), RST_O);
        chk16({tag, "_async"}, stall_count, 16'd0);
        drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk6({tag, "_held"}, obs_vec(), RST_O);
        reset = 1'b1;
        exp_sc = 16'd0;
    endtask

    initial begin
        int tmp;
        #2;
        chk6("reset_state", obs_vec(), RST_O);
        chk16("reset_state", stall_count, 16'd0);
        @(negedge clk);
        reset = 1'b1;

        cyc("idle0", 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, RUN_O);
        cyc("idle1", 4'd1, 4'd2, 1, 1, 0, 4'd5, 0, 0, RUN_O);

        // load r3 followed by a reader of r3: two hold cycles
        cyc("lu_rs1_c1", 4'd3, 4'd0, 1, 0, 0, 4'd3, 1, 0, STALL_O);
        cyc("lu_rs1_c2", 4'd3, 4'd0, 1, 0, 0, 4'd3, 1, 0, STALL_O);
        cyc("lu_rs1_done", 4'd3, 4'd0, 1, 0, 0, 4'd0, 0, 0, RUN_O);

        cyc("r0_load", 4'd0, 4'd0, 1, 1, 0, 4'd0, 1, 0, RUN_O);
        cyc("unused_rs1", 4'd5, 4'd1, 0, 1, 0, 4'd5, 1, 0, RUN_O);
        cyc("not_load", 4'd6, 4'd0, 1, 0, 0, 4'd6, 0, 0, RUN_O);

        cyc("lu_rs2_c1", 4'd1, 4'd7, 0, 1, 0, 4'd7, 1, 0, STALL_O);
        cyc("lu_rs2_c2", 4'd1, 4'd7, 0, 1, 0, 4'd7, 1, 0, STALL_O);
        cyc("lu_rs2_done", 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, RUN_O);

        // branch beats a simultaneous hazard; halt inside the flush cycle is ignored
        cyc("br_hazard", 4'd3, 4'd0, 1, 0, 0, 4'd3, 1, 1, BR_O);
        cyc("flush_haz_halt", 4'd3, 4'd0, 1, 0, 1, 4'd3, 1, 0, FLUSH_O);
        cyc("br_in_flush", 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, BR_O);
        cyc("flush_halt", 4'd0, 4'd0, 0, 0, 1, 4'd0, 0, 0, FLUSH_O);
        cyc("after_flush", 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, RUN_O);

        cyc("ls_then_br_c1", 4'd2, 4'd0, 1, 0, 0, 4'd2, 1, 0, STALL_O);
        cyc("ls_then_br_br", 4'd2, 4'd0, 1, 0, 0, 4'd2, 1, 1, BR_O);
        cyc("ls_then_br_fl", 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, FLUSH_O);
        cyc("ls_then_br_run", 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, RUN_O);

        // reset arriving between clock edges while in LOAD_STALL
        cyc("pre_reset_haz", 4'd4, 4'd0, 1, 0, 0, 4'd4, 1, 0, STALL_O);
        do_reset("rst_in_stall");
        cyc("post_rst_run", 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, RUN_O);

        // continuous hazard well past the counter range
        cyc("sat_start", 4'd9, 4'd0, 1, 0, 0, 4'd9, 1, 0, STALL_O);
        repeat (70000) @(posedge clk);
        tmp = int'(exp_sc) + 70000;
        exp_sc = (tmp > 65535) ? 16'hFFFF : 16'(tmp);
        cyc("sat_hold", 4'd9, 4'd0, 1, 0, 0, 4'd9, 1, 0, STALL_O);
        cyc("sat_stay", 4'd9, 4'd0, 1, 0, 0, 4'd9, 1, 0, STALL_O);
        do_reset("rst_after_sat");

        // halt sticks through every input until reset
        cyc("halt_enter", 4'd0, 4'd0, 0, 0, 1, 4'd0, 0, 0, STALL_O);
        cyc("halt_br", 4'd3, 4'd0, 1, 0, 0, 4'd3, 1, 1, HALT_O);
        cyc("halt_haz", 4'd3, 4'd3, 1, 1, 1, 4'd3, 1, 0, HALT_O);
        cyc("halt_idle", 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, HALT_O);
        do_reset("rst_in_halt");
        cyc("post_halt_run", 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, RUN_O);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
